// File: rtl/uart_rx_port_if.sv
// -----------------------------------------------------------------------------
// uart_rx_port_if
//   CPU-side byte interface of the UART receiver.
//   Signals:
//     uart_read_end   CPU -> port  one-cycle acknowledge: byte consumed
//     uart_read_byte  port -> CPU  last correctly framed byte
//     int0            port -> CPU  byte valid / interrupt request (level)
//     frame_err       port -> CPU  sticky: stop bit sampled low
//     overrun         port -> CPU  sticky: byte arrived while previous unread
//   Modports:
//     master  CPU side (drives the acknowledge)
//     slave   receiver side (drives byte and status)
// -----------------------------------------------------------------------------
interface uart_rx_port_if;
  logic       uart_read_end;
  logic [7:0] uart_read_byte;
  logic       int0;
  logic       frame_err;
  logic       overrun;

  modport master (
    output uart_read_end,
    input  uart_read_byte,
    input  int0,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  uart_read_end,
    output uart_read_byte,
    output int0,
    output frame_err,
    output overrun
  );
endinterface

// File: rtl/uart_rx_port.sv
// -----------------------------------------------------------------------------
// uart_rx_port
//   8N1 UART receiver (LSB first) with a one-byte holding register for the CPU.
//   A received byte is presented on uart_read_byte with int0 high until the CPU
//   acknowledges it with a one-cycle uart_read_end pulse.
//   Ports:
//     clk   in   system clock, rising edge
//     rst   in   synchronous reset, active low
//     rx    in   asynchronous serial line, idle high
//     cpu   slave modport of uart_rx_port_if (byte, int0, frame_err,
//           overrun out; uart_read_end in)
//   Parameters:
//     CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//     SYNC_STAGES   flops in the rx synchroniser (>= 2)
// -----------------------------------------------------------------------------
module uart_rx_port #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  uart_rx_port_if.slave  cpu
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_t        state_q,   state_d;
  logic [TW-1:0] tick_q,    tick_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q,   shift_d;
  logic          commit_s;
  logic          stop_bad_s;

  logic [7:0]    byte_q, byte_d;
  logic          int0_q, int0_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q,  ovr_d;

  // rx input synchroniser; flops preset to the idle level so reset looks idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // receive state machine registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tick_q    <= '0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // next-state logic; the tick counter restarts at zero on every state entry
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + TW'(1'b1);
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    commit_s   = 1'b0;
    stop_bad_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // re-check the line at mid start bit to reject short glitches
        if (tick_q == TICK_HALF) begin
          tick_d    = '0;
          bit_cnt_d = 3'd0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        // sampling points are now mid-bit, a full bit period apart
        if (tick_q == TICK_LAST) begin
          tick_d    = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (rx_s) begin
            commit_s = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            stop_bad_s = 1'b1;
            state_d    = ST_BREAK;
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_BREAK: begin
        // a line held low must return high before a new start bit counts
        tick_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tick_d    = '0;
        bit_cnt_d = 3'd0;
      end
    endcase
  end

  // holding register and status update; a set condition wins over the ack
  always_comb begin
    byte_d = byte_q;
    int0_d = int0_q;
    ferr_d = ferr_q;
    ovr_d  = ovr_q;
    if (cpu.uart_read_end) begin
      int0_d = 1'b0;
      ferr_d = 1'b0;
      ovr_d  = 1'b0;
    end else begin
      int0_d = int0_q;
    end
    if (commit_s) begin
      // an unread byte is kept; the newcomer is dropped and flagged
      if (int0_q && !cpu.uart_read_end) begin
        ovr_d = 1'b1;
      end else begin
        byte_d = shift_q;
        int0_d = 1'b1;
      end
    end else begin
      byte_d = byte_d;
    end
    if (stop_bad_s) begin
      ferr_d = 1'b1;
    end else begin
      ferr_d = ferr_d;
    end
  end

  // CPU-visible output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_q <= 8'h00;
      int0_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      byte_q <= byte_d;
      int0_q <= int0_d;
      ferr_q <= ferr_d;
      ovr_q  <= ovr_d;
    end
  end

  assign cpu.uart_read_byte = byte_q;
  assign cpu.int0           = int0_q;
  assign cpu.frame_err      = ferr_q;
  assign cpu.overrun        = ovr_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_port
//   Self-checking bench for uart_rx_port (CLKS_PER_BIT=16, SYNC_STAGES=2).
//   A table of frames with hand-derived expected outputs, hand-written
//   sequences for glitch and mid-frame reset, and random frames checked
//   against an event-level model of the holding register and flags.
// -----------------------------------------------------------------------------
module tb_uart_rx_port;
  localparam int C = 16;
  localparam int S = 2;
  // index of the clock edge (counted from the start bit) that samples the stop bit
  localparam int COMMIT_IDX = S + C / 2 + 9 * C;

  logic clk = 1'b0;
  logic rst;
  logic rx;

  always #5 clk = ~clk;

  uart_rx_port_if cpu_if ();

  uart_rx_port #(.CLKS_PER_BIT(C), .SYNC_STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .cpu (cpu_if)
  );

  int errors = 0;
  int checks = 0;

  // event-level model: what the CPU should see
  logic [7:0] m_byte;
  logic       m_int0, m_ferr, m_ovr;

  typedef struct {
    logic [7:0] data;
    logic       stop_ok;
    logic       ack_commit;
    logic       ack_after;
    logic [7:0] exp_byte;
    logic       exp_int0;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs [7];

  task automatic check1(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] b, input logic i,
                           input logic f, input logic o);
    check1({tag, ".byte"},      cpu_if.uart_read_byte, b);
    check1({tag, ".int0"},      {7'd0, cpu_if.int0},      {7'd0, i});
    check1({tag, ".frame_err"}, {7'd0, cpu_if.frame_err}, {7'd0, f});
    check1({tag, ".overrun"},   {7'd0, cpu_if.overrun},   {7'd0, o});
  endtask

  task automatic model_reset();
    m_byte = 8'h00; m_int0 = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  // a frame ends: good byte is accepted unless one is pending and not acked
  task automatic model_frame(input logic [7:0] d, input logic ok, input logic ackc);
    logic pending;
    pending = m_int0 && !ackc;
    if (ackc) begin
      m_int0 = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
    end
    if (!ok) m_ferr = 1'b1;
    else if (pending) m_ovr = 1'b1;
    else begin
      m_byte = d; m_int0 = 1'b1;
    end
  endtask

  task automatic model_ack();
    m_int0 = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // one serial frame; optional ack on the stop-sample edge; extra low time after stop
  task automatic send_frame(input logic [7:0] d, input logic ok, input logic ackc,
                            input int extra_low);
    for (int i = 0; i < 10 * C + extra_low; i++) begin
      int b;
      b = i / C;
      if (b == 0)      rx = 1'b0;
      else if (b <= 8) rx = d[b-1];
      else if (b == 9) rx = ok;
      else             rx = 1'b0;
      cpu_if.uart_read_end = (ackc && i == COMMIT_IDX);
      @(negedge clk);
    end
    rx = 1'b1;
    cpu_if.uart_read_end = 1'b0;
  endtask

  task automatic ack_pulse();
    cpu_if.uart_read_end = 1'b1;
    @(negedge clk);
    cpu_if.uart_read_end = 1'b0;
    model_ack();
  endtask

  initial begin
    //            data   ok    ackc  acka  byte   int0  ferr  ovr
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h77, 1'b1, 1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h22, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0};

    rst = 1'b0;
    rx = 1'b1;
    cpu_if.uart_read_end = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(4);

    // table-driven frames with hand-derived expectations
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].ack_commit,
                 vecs[v].stop_ok ? 0 : 2 * C);
      model_frame(vecs[v].data, vecs[v].stop_ok, vecs[v].ack_commit);
      idle(4);
      check_all($sformatf("vec%0d", v), vecs[v].exp_byte, vecs[v].exp_int0,
                vecs[v].exp_ferr, vecs[v].exp_ovr);
      if (vecs[v].ack_after) begin
        ack_pulse();
        check_all($sformatf("vec%0d.ack", v), vecs[v].exp_byte, 1'b0, 1'b0, 1'b0);
      end
    end

    // short low glitch must be rejected at mid start bit
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(2 * C);
    check_all("glitch", m_byte, 1'b0, 1'b0, 1'b0);

    // random frames against the model
    for (int r = 0; r < 10; r++) begin
      logic [7:0] d;
      logic ok, ackc, acka;
      d    = 8'($urandom_range(0, 255));
      ok   = ($urandom_range(0, 3) != 0);
      ackc = ($urandom_range(0, 3) == 0);
      acka = ($urandom_range(0, 1) == 1);
      send_frame(d, ok, ackc, ok ? 0 : 2 * C);
      model_frame(d, ok, ackc);
      idle(3);
      check_all($sformatf("rnd%0d", r), m_byte, m_int0, m_ferr, m_ovr);
      if (acka) begin
        ack_pulse();
        check_all($sformatf("rnd%0d.ack", r), m_byte, m_int0, m_ferr, m_ovr);
      end
    end

    // make int0 and the byte non-zero, then reset during data bit 3 of 8'hFF
    send_frame(8'hC3, 1'b1, 1'b0, 0);
    model_frame(8'hC3, 1'b1, 1'b0);
    idle(4);
    for (int i = 0; i < S + C / 2 + 3 * C + C / 2; i++) begin
      rx = (i < C) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    check_all("midreset", 8'h00, 1'b0, 1'b0, 1'b0);
    idle(6 * C);
    check_all("midreset.quiet", 8'h00, 1'b0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 0);
    model_frame(8'h5A, 1'b1, 1'b0);
    idle(4);
    check_all("after_reset", 8'h5A, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
